// File: rtl/map_tile_renderer_pkg.sv
// map_pkg: shared map geometry, address widths and tile code type for the map tile renderer.
// No ports; imported by the interface and the renderer.
package map_pkg;
   localparam int TILE_W      = 16;
   localparam int MAP_COLS    = 40;
   localparam int MAP_ROWS    = 30;
   localparam int TILE_ADDR_W = 11;
   localparam int FONT_ADDR_W = 5;
   typedef enum logic {FILL = 1'b0, WALL = 1'b1} tile_code_t;
endpackage

// File: rtl/map_tile_renderer_if.sv
// map_tile_renderer_if: bundle between the renderer and its surroundings (VGA coords, map RAM, font ROM, outputs).
// master: drives draw coords, frame_end, RAM/ROM read data; slave: the renderer, drives addresses and pixel results.
interface map_tile_renderer_if;
   import map_pkg::*;
   logic                   pix_valid;
   logic [9:0]             DrawX;
   logic [9:0]             DrawY;
   logic                   frame_end;
   logic [TILE_ADDR_W-1:0] tile_addr;
   tile_code_t             tile_code;
   logic [FONT_ADDR_W-1:0] font_addr;
   logic [TILE_W-1:0]      font_data;
   logic                   is_wall;
   logic                   out_valid;
   logic [9:0]             OutX;
   logic [9:0]             OutY;
   logic [18:0]            wall_count;
   modport master (
      output pix_valid, DrawX, DrawY, frame_end, tile_code, font_data,
      input  tile_addr, font_addr, is_wall, out_valid, OutX, OutY, wall_count
   );
   modport slave (
      input  pix_valid, DrawX, DrawY, frame_end, tile_code, font_data,
      output tile_addr, font_addr, is_wall, out_valid, OutX, OutY, wall_count
   );
endinterface

// File: rtl/map_tile_renderer.sv
// map_tile_renderer: 3-stage pipeline turning a draw coordinate into a wall flag via map RAM and font ROM, plus per-frame wall pixel count.
// Ports: Clk (pixel clock), Reset_n (async active-low), bus (slave: DrawX/DrawY/pix_valid/frame_end in,
// tile_addr/tile_code map RAM, font_addr/font_data font ROM, is_wall/out_valid/OutX/OutY/wall_count out).
module map_tile_renderer #(
   parameter int TILE_W   = map_pkg::TILE_W,
   parameter int MAP_COLS = map_pkg::MAP_COLS,
   parameter int MAP_ROWS = map_pkg::MAP_ROWS,
   parameter int MAP_X0   = 0,
   parameter int MAP_Y0   = 0
) (
   input logic                Clk,
   input logic                Reset_n,
   map_tile_renderer_if.slave bus
);
   import map_pkg::*;
   localparam int SH = $clog2(TILE_W);
   localparam logic [10:0] X_LO = 11'(MAP_X0);
   localparam logic [10:0] X_HI = 11'(MAP_X0 + MAP_COLS * TILE_W);
   localparam logic [10:0] Y_LO = 11'(MAP_Y0);
   localparam logic [10:0] Y_HI = 11'(MAP_Y0 + MAP_ROWS * TILE_W);
   logic [9:0]        w_lx, w_ly;
   logic              w_in_map;
   logic [18:0]       w_cnt;
   logic              r_v1, r_in1, r_v2, r_in2;
   logic [SH-1:0]     r_lx1, r_ly1, r_lx2;
   logic [9:0]        r_x1, r_y1, r_x2, r_y2;
   logic [TILE_W-1:0] r_row2;
   logic              r_valid, r_wall;
   logic [9:0]        r_ox, r_oy;
   logic [18:0]       r_cnt, r_wc;
   assign w_lx = bus.DrawX - X_LO[9:0];
   assign w_ly = bus.DrawY - Y_LO[9:0];
   assign w_in_map = {1'b0, bus.DrawX} >= X_LO && {1'b0, bus.DrawX} < X_HI &&
                     {1'b0, bus.DrawY} >= Y_LO && {1'b0, bus.DrawY} < Y_HI;
   assign bus.tile_addr = w_in_map ? TILE_ADDR_W'(w_ly[9:SH]) * TILE_ADDR_W'(MAP_COLS) + TILE_ADDR_W'(w_lx[9:SH]) : '0;
   // Off-map pixels fetch the fill glyph so stale RAM data never reaches the font ROM
   assign bus.font_addr = {bus.tile_code & r_in1, r_ly1};
   // Counter saturates instead of wrapping
   assign w_cnt = r_cnt + 19'(r_valid & r_wall & ~&r_cnt);
   assign bus.out_valid  = r_valid;
   assign bus.is_wall    = r_wall;
   assign bus.OutX       = r_ox;
   assign bus.OutY       = r_oy;
   assign bus.wall_count = r_wc;
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         {r_v1, r_in1, r_lx1, r_ly1, r_x1, r_y1} <= '0;
         {r_v2, r_in2, r_lx2, r_x2, r_y2, r_row2} <= '0;
         {r_valid, r_wall, r_ox, r_oy, r_cnt, r_wc} <= '0;
      end else begin
         r_v1   <= bus.pix_valid;
         r_in1  <= w_in_map;
         r_lx1  <= w_lx[SH-1:0];
         r_ly1  <= w_ly[SH-1:0];
         r_x1   <= bus.DrawX;
         r_y1   <= bus.DrawY;
         r_v2   <= r_v1;
         r_in2  <= r_in1;
         r_lx2  <= r_lx1;
         r_x2   <= r_x1;
         r_y2   <= r_y1;
         r_row2 <= bus.font_data;
         r_valid <= r_v2;
         // Bit TILE_W-1 is the leftmost pixel, so the column index is inverted
         r_wall  <= r_v2 & r_in2 & r_row2[~r_lx2];
         r_ox    <= r_v2 ? r_x2 : r_ox;
         r_oy    <= r_v2 ? r_y2 : r_oy;
         r_cnt   <= bus.frame_end ? '0 : w_cnt;
         r_wc    <= bus.frame_end ? w_cnt : r_wc;
      end
   end
endmodule

// File: tb/tb_map_tile_renderer.sv
// tb_map_tile_renderer: scoreboard bench driving two renderers (map at X0=0 and X0=64) with shared RAM/ROM models.
module tb_map_tile_renderer;
   import map_pkg::*;
   typedef struct {logic [9:0] x; logic [9:0] y; logic w; int t;} exp_t;
   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   int cyc = 0, n_vec = 0, n_err = 0, cnt_a = 0, cnt_b = 0;
   logic [9:0] last_xa = '0, last_ya = '0, last_xb = '0, last_yb = '0;
   exp_t qa[$], qb[$];
   exp_t ea, eb;
   bit ram [0:2047];
   logic [15:0] font [0:31];
   map_tile_renderer_if ia();
   map_tile_renderer_if ib();
   map_tile_renderer dut_a (.Clk(Clk), .Reset_n(Reset_n), .bus(ia));
   map_tile_renderer #(.MAP_X0(64)) dut_b (.Clk(Clk), .Reset_n(Reset_n), .bus(ib));
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc++;
   always @(posedge Clk) begin
      ia.tile_code <= tile_code_t'(ram[ia.tile_addr]);
      ib.tile_code <= tile_code_t'(ram[ib.tile_addr]);
   end
   assign ia.font_data = font[ia.font_addr];
   assign ib.font_data = font[ib.font_addr];
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask
   function automatic bit in_map(int x, int y, int x0);
      return x - x0 >= 0 && x - x0 < 640 && y >= 0 && y < 480;
   endfunction
   function automatic int ref_taddr(int x, int y, int x0);
      return in_map(x, y, x0) ? (y / 16) * 40 + (x - x0) / 16 : 0;
   endfunction
   function automatic logic ref_wall(int x, int y, int x0);
      logic [15:0] row;
      if (!in_map(x, y, x0)) return 1'b0;
      row = font[(ram[ref_taddr(x, y, x0)] ? 16 : 0) + y % 16];
      return row[15 - (x - x0) % 16];
   endfunction
   task automatic px(bit v, int x, int y, bit fe = 1'b0);
      @(posedge Clk); #1;
      ia.pix_valid = v; ib.pix_valid = v;
      ia.DrawX = 10'(x); ib.DrawX = 10'(x);
      ia.DrawY = 10'(y); ib.DrawY = 10'(y);
      ia.frame_end = fe; ib.frame_end = fe;
      if (v) begin
         qa.push_back('{x: 10'(x), y: 10'(y), w: ref_wall(x, y, 0), t: cyc});
         qb.push_back('{x: 10'(x), y: 10'(y), w: ref_wall(x, y, 64), t: cyc});
      end
      #1;
      chk("a_tile_addr", 32'(ia.tile_addr), ref_taddr(x, y, 0));
      chk("b_tile_addr", 32'(ib.tile_addr), ref_taddr(x, y, 64));
   endtask
   task automatic flush();
      repeat (5) px(0, 0, 0);
   endtask
   task automatic frame_check();
      px(0, 0, 0, 1);
      px(0, 0, 0);
      chk("a_wall_count", 32'(ia.wall_count), cnt_a);
      chk("b_wall_count", 32'(ib.wall_count), cnt_b);
      cnt_a = 0; cnt_b = 0;
   endtask
   always @(negedge Clk) if (Reset_n) begin
      if (ia.out_valid) begin
         chk("a_pending", 32'(qa.size() > 0), 1);
         if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("a_outx", 32'(ia.OutX), 32'(ea.x));
            chk("a_outy", 32'(ia.OutY), 32'(ea.y));
            chk("a_is_wall", 32'(ia.is_wall), 32'(ea.w));
            chk("a_latency", cyc - ea.t, 3);
            if (ea.w) cnt_a++;
         end
         last_xa = ia.OutX; last_ya = ia.OutY;
      end else begin
         chk("a_idle_wall", 32'(ia.is_wall), 0);
         chk("a_hold_x", 32'(ia.OutX), 32'(last_xa));
         chk("a_hold_y", 32'(ia.OutY), 32'(last_ya));
      end
   end
   always @(negedge Clk) if (Reset_n) begin
      if (ib.out_valid) begin
         chk("b_pending", 32'(qb.size() > 0), 1);
         if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_outx", 32'(ib.OutX), 32'(eb.x));
            chk("b_outy", 32'(ib.OutY), 32'(eb.y));
            chk("b_is_wall", 32'(ib.is_wall), 32'(eb.w));
            chk("b_latency", cyc - eb.t, 3);
            if (eb.w) cnt_b++;
         end
         last_xb = ib.OutX; last_yb = ib.OutY;
      end else begin
         chk("b_idle_wall", 32'(ib.is_wall), 0);
         chk("b_hold_x", 32'(ib.OutX), 32'(last_xb));
         chk("b_hold_y", 32'(ib.OutY), 32'(last_yb));
      end
   end
   initial begin
      {ia.pix_valid, ib.pix_valid, ia.frame_end, ib.frame_end} = '0;
      {ia.DrawX, ib.DrawX, ia.DrawY, ib.DrawY} = '0;
      foreach (ram[i]) ram[i] = 1'b0;
      foreach (font[i]) font[i] = i < 16 ? 16'h0000 : 16'hFFFF;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_out_valid", 32'(ia.out_valid), 0);
      chk("rst_is_wall", 32'(ia.is_wall), 0);
      chk("rst_outx", 32'(ia.OutX), 0);
      chk("rst_outy", 32'(ia.OutY), 0);
      chk("rst_wall_count", 32'(ia.wall_count), 0);
      chk("rst_font_addr", 32'(ia.font_addr), 0);
      chk("rst_b_out_valid", 32'(ib.out_valid), 0);
      @(posedge Clk); #1 Reset_n = 1'b1;
      // empty map: nothing is a wall, coords and latency tracked per pixel
      for (int x = 0; x < 640; x++) px(1, x, 5);
      flush();
      frame_check();
      // single wall tile at col 2, row 1
      ram[42] = 1'b1;
      px(1, 37, 20);
      px(0, 0, 0);
      chk("a_font_addr", 32'(ia.font_addr), 32'b10100);
      chk("b_font_addr", 32'(ib.font_addr), 32'b00100);
      px(1, 31, 20);
      px(1, 48, 20);
      flush();
      frame_check();
      // all-wall map, edges of the offset map
      foreach (ram[i]) ram[i] = 1'b1;
      foreach (qa[i]) chk("q_stale", 1, 0);
      px(1, 63, 0); px(1, 64, 0); px(1, 703, 0); px(1, 704, 0);
      flush();
      frame_check();
      // 10 walls with 3 bubbles, frame_end coincident with last output
      for (int i = 0; i < 13; i++) px(!(i == 3 || i == 7 || i == 10), 100 + i, 50);
      px(0, 0, 0); px(0, 0, 0); px(0, 0, 0, 1); px(0, 0, 0);
      chk("a_coincident_count", 32'(ia.wall_count), 10);
      chk("b_coincident_count", 32'(ib.wall_count), 10);
      chk("a_model_count", cnt_a, 10);
      cnt_a = 0; cnt_b = 0;
      frame_check();
      // reset in the middle of a stream
      for (int x = 200; x < 204; x++) px(1, x, 40);
      flush();
      frame_check();
      for (int x = 300; x < 306; x++) px(1, x, 41);
      @(posedge Clk); #1;
      Reset_n = 1'b0; ia.pix_valid = 1'b0; ib.pix_valid = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(ia.out_valid), 0);
      chk("mid_rst_is_wall", 32'(ia.is_wall), 0);
      chk("mid_rst_wall_count", 32'(ia.wall_count), 0);
      chk("mid_rst_b_wall_count", 32'(ib.wall_count), 0);
      qa.delete(); qb.delete();
      cnt_a = 0; cnt_b = 0;
      last_xa = '0; last_ya = '0; last_xb = '0; last_yb = '0;
      @(posedge Clk); #1 Reset_n = 1'b1;
      px(0, 0, 0); px(0, 0, 0);
      for (int x = 310; x < 316; x++) px(1, x, 42);
      flush();
      frame_check();
      // fill/wall boundary, then a patterned glyph row for bit ordering
      foreach (ram[i]) ram[i] = 1'b0;
      ram[1] = 1'b1;
      for (int x = 10; x < 23; x++) px(1, x, 3);
      flush();
      font[19] = 16'hA5C3;
      for (int x = 0; x <= 100; x++) px(1, x, 3);
      flush();
      frame_check();
      chk("a_drain", qa.size(), 0);
      chk("b_drain", qb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
